// File: rtl/apg_stream_bridge.sv
// apg_stream_bridge
//   AXI-Stream front/back end for the arbitrary pattern generator (axi_clk).
//   Inbound stream -> spaced write_channel/wrStrobe writes while idle.
//   start arms a shot, waits for the generator to finish and return to idle,
//   then drains captured samples via rdStrobe into an outbound stream with tlast.
// Ports
//   axi_clk, axi_resetn        clock, async active-low reset
//   s_t*                       inbound pattern samples
//   m_t*                       outbound captured samples
//   start/n_samples/soft_clear control; busy/done/err/load_count status
//   apg_*                      generator register interface
module apg_stream_bridge #(
  parameter int NUM_SIG  = 14,
  parameter int NUM_SAMP = 128,
  parameter int TIMEOUT  = 2**20
) (
  input  logic               axi_clk,
  input  logic               axi_resetn,
  input  logic [NUM_SIG-1:0] s_tdata,
  input  logic               s_tvalid,
  output logic               s_tready,
  output logic [NUM_SIG-1:0] m_tdata,
  output logic               m_tvalid,
  input  logic               m_tready,
  output logic               m_tlast,
  input  logic               start,
  input  logic [31:0]        n_samples,
  input  logic               soft_clear,
  output logic               busy,
  output logic               done,
  output logic [2:0]         err,
  output logic [31:0]        load_count,
  output logic [NUM_SIG-1:0] apg_write_channel,
  output logic               apg_wr_strobe,
  input  logic [NUM_SIG-1:0] apg_read_channel,
  output logic               apg_rd_strobe,
  output logic               apg_run,
  output logic               apg_clear,
  output logic [31:0]        apg_n_samples,
  input  logic [2:0]         apg_status
);
  localparam int CW = $clog2(NUM_SAMP + 1);

  typedef enum logic [2:0] {
    IDLE, ARM, WAIT_DONE, WAIT_IDLE, DRAIN_PRESENT, DRAIN_STEP
  } state_t;

  state_t             state_q, state_d;
  logic               rst_done_q;
  logic [1:0]         wcnt_q;
  logic               wr_strobe_q;
  logic [NUM_SIG-1:0] wdata_q, mdata_q;
  logic [31:0]        load_count_q, nsamp_q, tmo_q;
  logic               pend_q, done_q, clear_q;
  logic [CW-1:0]      neff_q, idx_q;
  logic [1:0]         step_q;
  logic [2:0]         err_q;

  logic        idle, acc, ovf, wr_go, req, launch, zero_start;
  logic        waiting, tmo_hit, tmo_abort, last_beat, hs, enter_present;
  logic [31:0] n_cur;

  assign idle      = (state_q == IDLE);
  // No new word while a write is in flight or a start waits for the sequencer.
  assign s_tready  = rst_done_q & idle & (wcnt_q == 2'd0) & ~pend_q;
  assign acc       = s_tvalid & s_tready & ~soft_clear;
  assign ovf       = acc & (load_count_q == 32'(NUM_SAMP));
  assign wr_go     = acc & ~ovf;
  assign req       = idle & (start | pend_q) & ~soft_clear;
  assign launch    = req & (wcnt_q == 2'd0) & ~acc;
  // A start seen this cycle has not been latched yet.
  assign n_cur      = start ? n_samples : nsamp_q;
  assign zero_start = launch & (n_cur == 32'd0);
  assign waiting   = (state_q == WAIT_DONE) | (state_q == WAIT_IDLE);
  assign tmo_hit   = (TIMEOUT != 0) & waiting & (tmo_q == 32'(TIMEOUT - 1));
  assign last_beat = (idx_q + CW'(1)) == neff_q;
  assign hs        = (state_q == DRAIN_PRESENT) & m_tready;
  assign enter_present = (state_d == DRAIN_PRESENT) & (state_q != DRAIN_PRESENT);

  // state register
  always_ff @(posedge axi_clk or negedge axi_resetn)
    if (!axi_resetn) state_q <= IDLE;
    else             state_q <= state_d;

  // next state
  always_comb begin
    state_d   = state_q;
    tmo_abort = 1'b0;
    if (soft_clear) state_d = IDLE;
    else begin
      case (state_q)
        IDLE:      if (launch && n_cur != 32'd0) state_d = ARM;
        ARM:       state_d = WAIT_DONE;
        WAIT_DONE:
          if (apg_status[1:0] == 2'd2) state_d = WAIT_IDLE;
          else if (tmo_hit) begin state_d = IDLE; tmo_abort = 1'b1; end
        // Triggered must also be clear before the capture buffer is read.
        WAIT_IDLE:
          if (apg_status == 3'b000) state_d = DRAIN_PRESENT;
          else if (tmo_hit) begin state_d = IDLE; tmo_abort = 1'b1; end
        DRAIN_PRESENT: if (m_tready) state_d = last_beat ? IDLE : DRAIN_STEP;
        DRAIN_STEP:    if (step_q == 2'd2) state_d = DRAIN_PRESENT;
        default:       state_d = IDLE;
      endcase
    end
  end

  // outputs
  always_comb begin
    apg_run       = (state_q == ARM);
    apg_rd_strobe = (state_q == DRAIN_STEP) & (step_q == 2'd0);
    m_tvalid      = (state_q == DRAIN_PRESENT);
    m_tlast       = m_tvalid & last_beat;
    busy          = ~idle | (wcnt_q != 2'd0) | pend_q;
  end

  assign m_tdata           = mdata_q;
  assign done              = done_q;
  assign err               = err_q;
  assign load_count        = load_count_q;
  assign apg_write_channel = wdata_q;
  assign apg_wr_strobe     = wr_strobe_q;
  assign apg_clear         = clear_q;
  assign apg_n_samples     = nsamp_q;

  // write sequencer: strobe in C+1, data held and ready low through C+3
  always_ff @(posedge axi_clk or negedge axi_resetn)
    if (!axi_resetn) begin
      rst_done_q  <= 1'b0;
      wcnt_q      <= 2'd0;
      wr_strobe_q <= 1'b0;
      wdata_q     <= '0;
    end else begin
      rst_done_q <= 1'b1;
      if (soft_clear) begin
        wcnt_q      <= 2'd0;
        wr_strobe_q <= 1'b0;
      end else if (wr_go) begin
        wcnt_q      <= 2'd3;
        wr_strobe_q <= 1'b1;
        wdata_q     <= s_tdata;
      end else begin
        wr_strobe_q <= 1'b0;
        if (wcnt_q != 2'd0) wcnt_q <= wcnt_q - 2'd1;
      end
    end

  // shot control, drain datapath and status
  always_ff @(posedge axi_clk or negedge axi_resetn)
    if (!axi_resetn) begin
      load_count_q <= '0;
      nsamp_q      <= '0;
      neff_q       <= '0;
      pend_q       <= 1'b0;
      done_q       <= 1'b0;
      clear_q      <= 1'b0;
      err_q        <= '0;
      idx_q        <= '0;
      step_q       <= '0;
      tmo_q        <= '0;
      mdata_q      <= '0;
    end else begin
      clear_q <= soft_clear | tmo_abort;
      done_q  <= ~soft_clear & ((hs & last_beat) | zero_start);
      pend_q  <= req & ~launch;

      if (soft_clear)            load_count_q <= '0;
      else if (hs && last_beat)  load_count_q <= '0;
      else if (wr_go)            load_count_q <= load_count_q + 32'd1;

      if (soft_clear) err_q <= '0;
      else            err_q <= err_q | {zero_start, tmo_abort, ovf};

      if (idle && start && !soft_clear) begin
        nsamp_q <= n_samples;
        neff_q  <= (n_samples > 32'(NUM_SAMP)) ? CW'(NUM_SAMP) : n_samples[CW-1:0];
      end

      if (enter_present) begin
        mdata_q <= apg_read_channel;
        idx_q   <= (state_q == DRAIN_STEP) ? idx_q + CW'(1) : '0;
      end

      step_q <= (state_q == DRAIN_STEP) ? step_q + 2'd1 : 2'd0;

      // Restart the count on every state change so each wait gets a full window.
      if (state_d != state_q || !waiting) tmo_q <= '0;
      else                                tmo_q <= tmo_q + 32'd1;
    end

endmodule

// File: tb/tb_apg_stream_bridge.sv
// Self-checking bench for apg_stream_bridge with a small generator stand-in
// (capture buffer served on read_channel, read pointer stepped by rdStrobe).
module tb_apg_stream_bridge;
  localparam int NS    = 14;
  localparam int NSAMP = 128;
  localparam int TMO   = 64;
  localparam int HN    = 16384;

  logic          clk, rstn;
  logic [NS-1:0] s_tdata, m_tdata, apg_write_channel, apg_read_channel;
  logic          s_tvalid, s_tready, m_tvalid, m_tready, m_tlast;
  logic          start, soft_clear, busy, done;
  logic [31:0]   n_samples, load_count, apg_n_samples;
  logic [2:0]    err, apg_status;
  logic          apg_wr_strobe, apg_rd_strobe, apg_run, apg_clear;

  apg_stream_bridge #(.NUM_SIG(NS), .NUM_SAMP(NSAMP), .TIMEOUT(TMO)) dut (
    .axi_clk(clk), .axi_resetn(rstn),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .start(start), .n_samples(n_samples), .soft_clear(soft_clear),
    .busy(busy), .done(done), .err(err), .load_count(load_count),
    .apg_write_channel(apg_write_channel), .apg_wr_strobe(apg_wr_strobe),
    .apg_read_channel(apg_read_channel), .apg_rd_strobe(apg_rd_strobe),
    .apg_run(apg_run), .apg_clear(apg_clear), .apg_n_samples(apg_n_samples),
    .apg_status(apg_status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int lc_model = 0;

  // generator stand-in: capture buffer indexed by a read pointer
  logic [NS-1:0] cap [0:255];
  int rptr;
  always @(posedge clk or negedge rstn)
    if (!rstn)              rptr <= 0;
    else if (apg_run)       rptr <= 0;
    else if (apg_rd_strobe) rptr <= rptr + 1;
  assign apg_read_channel = cap[rptr[7:0]];

  // per-cycle history sampled mid-cycle
  int cyc = 0;
  logic wr_h [0:HN-1];
  logic rd_h [0:HN-1];
  logic run_h [0:HN-1];
  logic clr_h [0:HN-1];
  logic done_h [0:HN-1];
  logic mv_h [0:HN-1];
  logic tv_h [0:HN-1];
  logic tr_h [0:HN-1];
  logic [NS-1:0] wc_h [0:HN-1];
  always @(negedge clk) begin
    if (cyc < HN) begin
      wr_h[cyc] = apg_wr_strobe;  rd_h[cyc] = apg_rd_strobe;
      run_h[cyc] = apg_run;       clr_h[cyc] = apg_clear;
      done_h[cyc] = done;         mv_h[cyc] = m_tvalid;
      tv_h[cyc] = s_tvalid;       tr_h[cyc] = s_tready;
      wc_h[cyc] = apg_write_channel;
    end
    cyc++;
  end

  // 0 wr, 1 rd, 2 run, 3 clear, 4 done, 5 m_tvalid
  function automatic int cnt(input int sel, input int a, input int b);
    int n = 0;
    for (int c = a; c < b && c < HN; c++) begin
      if (sel == 0 && wr_h[c] === 1'b1) n++;
      if (sel == 1 && rd_h[c] === 1'b1) n++;
      if (sel == 2 && run_h[c] === 1'b1) n++;
      if (sel == 3 && clr_h[c] === 1'b1) n++;
      if (sel == 4 && done_h[c] === 1'b1) n++;
      if (sel == 5 && mv_h[c] === 1'b1) n++;
    end
    return n;
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    soft_clear = 1'b1; cycles(1); soft_clear = 1'b0; cycles(3);
    lc_model = 0;
  endtask

  task automatic pulse_start(input int n);
    n_samples = n; start = 1'b1; cycles(1); start = 1'b0;
  endtask

  // returns history index of the run pulse, or -1
  task automatic wait_run(output int r);
    int ci;
    r = -1;
    for (int i = 0; i < 20 && r < 0; i++) begin
      ci = cyc; @(negedge clk);
      if (apg_run === 1'b1) r = ci;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    int c;
    rstn = 1'b0; s_tvalid = 1'b1; s_tdata = 14'h1234;
    cycles(3);
    @(negedge clk);
    tests++;
    if ({s_tready, apg_wr_strobe, busy, done, err, load_count, m_tvalid, m_tlast,
         apg_run, apg_clear, apg_rd_strobe, apg_write_channel, m_tdata, apg_n_samples} !== '0) begin
      fails++; $display("FAIL reset_outputs: some output nonzero in reset (s_tready=%b strobe=%b busy=%b)",
                        s_tready, apg_wr_strobe, busy);
    end
    @(posedge clk); #1; rstn = 1'b1;
    for (int i = 0; i < 10 && s_tvalid; i++) begin
      @(negedge clk);
      if (s_tready === 1'b1) begin @(posedge clk); #1; s_tvalid = 1'b0; end
      else begin @(posedge clk); #1; end
    end
    s_tvalid = 1'b0;
    cycles(4);
    c = -1;
    for (int k = 0; k < cyc && c < 0; k++) if (tv_h[k] === 1'b1 && tr_h[k] === 1'b1) c = k;
    tests++;
    if (c < 0) begin fails++; $display("FAIL reset_ready: s_tready never rose after reset"); end
    else begin
      tests++;
      if ({wr_h[c], wr_h[c+1]} !== 2'b01) begin
        fails++; $display("FAIL reset_first_strobe: strobe at accept/next = %b%b, want 01", wr_h[c], wr_h[c+1]);
      end
      tests++;
      if (wc_h[c+1] !== 14'h1234) begin
        fails++; $display("FAIL reset_first_data: got %h want 1234", wc_h[c+1]);
      end
    end
    tests++;
    if (load_count !== 32'd1) begin fails++; $display("FAIL reset_load_count: got %0d want 1", load_count); end
    do_clear();
  endtask

  task automatic test_load(input int n, input bit fixed);
    logic [NS-1:0] w [$];
    int st [$];
    int s, e, i, guard, exp_n, room;
    bit acc;
    for (int k = 0; k < n; k++) w.push_back(fixed ? NS'(k + 1) : NS'($urandom));
    room  = NSAMP - lc_model;
    exp_n = (n < room) ? n : room;
    s = cyc; s_tdata = w[0]; s_tvalid = 1'b1; i = 0; guard = 0;
    while (i < n && guard < 2000) begin
      @(negedge clk); acc = (s_tready === 1'b1);
      @(posedge clk); #1; guard++;
      if (acc) begin i++; if (i < n) s_tdata = w[i]; end
    end
    s_tvalid = 1'b0;
    tests++;
    if (i !== n) begin fails++; $display("FAIL load_accept: accepted %0d want %0d", i, n); end
    cycles(6); e = cyc;
    for (int c = s; c < e; c++) if (wr_h[c] === 1'b1) st.push_back(c);
    tests++;
    if (st.size() !== exp_n) begin
      fails++; $display("FAIL load_strobes: got %0d strobes want %0d", st.size(), exp_n);
    end
    for (int k = 0; k < st.size() && k < exp_n; k++) begin
      tests++;
      if (wc_h[st[k]] !== w[k] || wc_h[st[k]+1] !== w[k] || wc_h[st[k]+2] !== w[k]) begin
        fails++; $display("FAIL load_data[%0d]: got %h/%h/%h want %h", k,
                          wc_h[st[k]], wc_h[st[k]+1], wc_h[st[k]+2], w[k]);
      end
      if (k > 0) begin
        tests++;
        if (st[k] - st[k-1] !== 4) begin
          fails++; $display("FAIL load_spacing[%0d]: got %0d want 4", k, st[k] - st[k-1]);
        end
      end
    end
    lc_model += exp_n;
    tests++;
    if (load_count !== 32'(lc_model)) begin
      fails++; $display("FAIL load_count: got %0d want %0d", load_count, lc_model);
    end
    tests++;
    if (err[0] !== (n > exp_n)) begin
      fails++; $display("FAIL load_overflow_flag: got %b want %b", err[0], n > exp_n);
    end
  endtask

  task automatic test_shot(input int n, input int stall_beat, input int stall_len, input bit rnd);
    int neff, s, e, r, beats, stall_cnt, guard, ci, last_hs;
    bit rdy;
    neff = (n > NSAMP) ? NSAMP : n;
    for (int k = 0; k < 256; k++) cap[k] = rnd ? NS'($urandom) : NS'(10 + k);
    s = cyc;
    pulse_start(n);
    wait_run(r);
    tests++;
    if (r < 0) begin fails++; $display("FAIL shot_run: no run pulse for n=%0d", n); end
    apg_status = 3'd1; cycles(1 + $urandom_range(0, 4));
    apg_status = 3'd2; cycles(1 + $urandom_range(0, 2));
    apg_status = 3'b100; cycles($urandom_range(0, 2));
    tests++;
    if (m_tvalid !== 1'b0) begin fails++; $display("FAIL shot_early_drain: m_tvalid=%b want 0", m_tvalid); end
    apg_status = 3'd0;
    beats = 0; stall_cnt = 0; guard = 0; last_hs = -100;
    while (beats < neff && guard < 4000) begin
      rdy = 1'b1;
      if (m_tvalid === 1'b1 && beats == stall_beat && stall_cnt < stall_len) begin
        rdy = 1'b0; stall_cnt++;
      end
      if (rnd && $urandom_range(0, 3) == 0) rdy = 1'b0;
      m_tready = rdy;
      ci = cyc;
      @(negedge clk);
      if (m_tvalid === 1'b1) begin
        tests++;
        if (m_tdata !== cap[beats] || m_tlast !== (beats == neff - 1)) begin
          fails++; $display("FAIL shot_beat[%0d]: data=%h last=%b want data=%h last=%b",
                            beats, m_tdata, m_tlast, cap[beats], beats == neff - 1);
        end
        if (m_tready) begin
          if (beats > 0) begin
            tests++;
            if (ci - last_hs < 4) begin
              fails++; $display("FAIL shot_gap[%0d]: got %0d cycles want >=4", beats, ci - last_hs);
            end
          end
          last_hs = ci; beats++;
        end
      end
      @(posedge clk); #1; guard++;
    end
    m_tready = 1'b0;
    tests++;
    if (beats !== neff) begin fails++; $display("FAIL shot_beats: got %0d want %0d", beats, neff); end
    cycles(3); e = cyc;
    tests++;
    if (cnt(2, s, e) !== 1) begin fails++; $display("FAIL shot_run_count: got %0d want 1", cnt(2, s, e)); end
    tests++;
    if (cnt(1, s, e) !== neff - 1) begin
      fails++; $display("FAIL shot_rd_count: got %0d want %0d", cnt(1, s, e), neff - 1);
    end
    tests++;
    if (cnt(4, s, e) !== 1 || done_h[last_hs + 1] !== 1'b1) begin
      fails++; $display("FAIL shot_done: count=%0d after_last=%b want 1/1", cnt(4, s, e), done_h[last_hs + 1]);
    end
    tests++;
    if ({busy, m_tvalid, load_count} !== '0 || apg_n_samples !== 32'(n)) begin
      fails++; $display("FAIL shot_end: busy=%b tvalid=%b load=%0d nsamp=%0d want 0/0/0/%0d",
                        busy, m_tvalid, load_count, apg_n_samples, n);
    end
    lc_model = 0;
  endtask

  task automatic test_zero_len();
    int ci, e;
    ci = cyc;
    pulse_start(0);
    cycles(10); e = cyc;
    tests++;
    if (done_h[ci + 1] !== 1'b1 || cnt(4, ci, e) !== 1) begin
      fails++; $display("FAIL zero_done: next=%b count=%0d want 1/1", done_h[ci + 1], cnt(4, ci, e));
    end
    tests++;
    if (cnt(2, ci, e) !== 0 || cnt(5, ci, e) !== 0) begin
      fails++; $display("FAIL zero_activity: runs=%0d beats=%0d want 0/0", cnt(2, ci, e), cnt(5, ci, e));
    end
    tests++;
    if (err !== 3'b100) begin fails++; $display("FAIL zero_err: got %b want 100", err); end
    do_clear();
  endtask

  task automatic test_pending_start();
    int ci, e;
    s_tdata = NS'($urandom); s_tvalid = 1'b1;
    @(negedge clk);
    tests++;
    if (s_tready !== 1'b1) begin fails++; $display("FAIL pend_ready: got %b want 1", s_tready); end
    @(posedge clk); #1; s_tvalid = 1'b0;
    ci = cyc;
    pulse_start(0);
    cycles(10); e = cyc;
    tests++;
    if (cnt(0, ci - 1, e) !== 1) begin fails++; $display("FAIL pend_strobe: got %0d want 1", cnt(0, ci - 1, e)); end
    tests++;
    if (cnt(4, ci, e) !== 1 || done_h[ci + 1] !== 1'b0) begin
      fails++; $display("FAIL pend_done: count=%0d immediate=%b want 1/0", cnt(4, ci, e), done_h[ci + 1]);
    end
    tests++;
    if (err[2] !== 1'b1) begin fails++; $display("FAIL pend_err: got %b want 1", err[2]); end
    do_clear();
  endtask

  task automatic test_timeout();
    int s, r, e, pos;
    s = cyc;
    pulse_start(5);
    wait_run(r);
    tests++;
    if (r < 0) begin fails++; $display("FAIL tmo_run: no run pulse"); r = s; end
    apg_status = 3'd1;
    cycles(TMO + 20); e = cyc;
    pos = -1;
    for (int c = r; c < e; c++) if (clr_h[c] === 1'b1 && pos < 0) pos = c;
    tests++;
    if (cnt(3, s, e) !== 1 || pos < r + TMO || pos > r + TMO + 2) begin
      fails++; $display("FAIL tmo_clear: pulses=%0d at +%0d want 1 at +%0d..+%0d",
                        cnt(3, s, e), pos - r, TMO, TMO + 2);
    end
    tests++;
    if (err !== 3'b010 || busy !== 1'b0 || cnt(4, s, e) !== 0) begin
      fails++; $display("FAIL tmo_state: err=%b busy=%b done=%0d want 010/0/0", err, busy, cnt(4, s, e));
    end
    apg_status = 3'd0;
    do_clear();
  endtask

  task automatic test_soft_clear_drain();
    int r, beats, guard;
    for (int k = 0; k < 256; k++) cap[k] = NS'($urandom);
    pulse_start(6);
    wait_run(r);
    apg_status = 3'd1; cycles(2); apg_status = 3'd2; cycles(2); apg_status = 3'd0;
    m_tready = 1'b1; beats = 0; guard = 0;
    while (beats < 2 && guard < 100) begin
      @(negedge clk); if (m_tvalid === 1'b1) beats++;
      @(posedge clk); #1; guard++;
    end
    m_tready = 1'b0;
    for (int i = 0; i < 10 && m_tvalid !== 1'b1; i++) cycles(1);
    tests++;
    if (m_tvalid !== 1'b1 || r < 0) begin fails++; $display("FAIL sc_setup: m_tvalid=%b run=%0d", m_tvalid, r); end
    soft_clear = 1'b1; cycles(1); soft_clear = 1'b0;
    @(negedge clk);
    tests++;
    if (m_tvalid !== 1'b0 || apg_clear !== 1'b1) begin
      fails++; $display("FAIL sc_next: m_tvalid=%b apg_clear=%b want 0/1", m_tvalid, apg_clear);
    end
    tests++;
    if ({busy, err, load_count} !== '0) begin
      fails++; $display("FAIL sc_state: busy=%b err=%b load=%0d want 0", busy, err, load_count);
    end
    @(posedge clk); #1; @(negedge clk);
    tests++;
    if (apg_clear !== 1'b0) begin fails++; $display("FAIL sc_pulse_len: apg_clear=%b want 0", apg_clear); end
    cycles(2);
    lc_model = 0;
  endtask

  task automatic test_strobe_rules();
    int both = 0, adj = 0;
    for (int c = 0; c + 1 < cyc && c + 1 < HN; c++) begin
      if (wr_h[c] === 1'b1 && rd_h[c] === 1'b1) both++;
      if ((wr_h[c] === 1'b1 || rd_h[c] === 1'b1) && (wr_h[c+1] === 1'b1 || rd_h[c+1] === 1'b1)) adj++;
    end
    tests++;
    if (both !== 0) begin fails++; $display("FAIL strobe_overlap: %0d cycles want 0", both); end
    tests++;
    if (adj !== 0) begin fails++; $display("FAIL strobe_adjacent: %0d pairs want 0", adj); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0; s_tdata = '0; s_tvalid = 1'b0; m_tready = 1'b0; start = 1'b0;
    n_samples = '0; soft_clear = 1'b0; apg_status = 3'd0;
    test_reset();
    test_load(5, 1'b1);
    do_clear();
    test_load(130, 1'b0);
    do_clear();
    test_shot(4, -1, 0, 1'b0);
    test_shot(4, 1, 10, 1'b0);
    for (int i = 0; i < 3; i++)
      test_shot($urandom_range(1, 10), $urandom_range(0, 5), $urandom_range(0, 8), 1'b1);
    test_load(7, 1'b0);
    test_shot(200, 3, 5, 1'b1);
    test_zero_len();
    test_pending_start();
    test_timeout();
    test_soft_clear_drain();
    test_strobe_rules();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/apg_stream_bridge.md
Name: apg_stream_bridge

Overview:
- AXI-Stream front/back end for the arbitrary pattern generator, in the axi_clk domain.
- Converts an inbound sample stream into correctly spaced write_channel/wrStrobe writes.
- Arms a shot, waits for completion, then drains the captured input samples via rdStrobe into an outbound AXI-Stream with tlast.
- Replaces per-sample CPU register pokes with DMA-driven streaming.

Parameters:
NUM_SIG, 14, sample width; must match the generator
NUM_SAMP, 128, generator buffer depth
TIMEOUT, 2**20, axi_clk cycles allowed in WAIT_DONE/WAIT_IDLE before abort; 0 disables

Ports:
axi_clk  in  1  clock
axi_resetn  in  1  reset, asynchronous, active-low
s_tdata  in  NUM_SIG  inbound pattern sample
s_tvalid  in  1  inbound valid
s_tready  out  1  inbound ready
m_tdata  out  NUM_SIG  captured sample out
m_tvalid  out  1  outbound valid
m_tready  in  1  outbound ready
m_tlast  out  1  last captured sample of shot
start  in  1  1-cycle pulse: run shot of n_samples
n_samples  in  32  requested shot length
soft_clear  in  1  1-cycle pulse: abort and clear
busy  out  1  FSM not IDLE or write sequencer active
done  out  1  1-cycle pulse at shot end
err  out  3  sticky: [0] overflow, [1] timeout, [2] zero-length start
load_count  out  32  samples written since last shot/clear
apg_write_channel  out  NUM_SIG  to generator write_channel
apg_wr_strobe  out  1  to write_channel_wrStrobe
apg_read_channel  in  NUM_SIG  from generator read_channel
apg_rd_strobe  out  1  to read_channel_rdStrobe
apg_run  out  1  to run
apg_clear  out  1  to clear
apg_n_samples  out  32  to n_samples, latched at start
apg_status  in  3  from status: [1:0] 0=IDLE, 1=TRANSACTION, 2=DONE; [2] triggered

Behaviour:
- Reset (asynchronous, active-low axi_resetn; clock axi_clk): all outputs 0 and FSM IDLE; s_tready=1 after reset deasserts.
- Write sequencer, active in IDLE only:
  - Accept on s_tvalid&s_tready at cycle C; register s_tdata onto apg_write_channel.
  - apg_wr_strobe=1 for exactly cycle C+1.
  - apg_write_channel held stable through C+3; s_tready=0 for C+1..C+3.
  - Max rate: 1 word per 4 cycles.
- Overflow: a word accepted while load_count==NUM_SAMP is dropped (no strobe) and sets err[0]; s_tready is not held low.
- FSM states IDLE, ARM, WAIT_DONE, WAIT_IDLE, DRAIN_PRESENT, DRAIN_STEP.
- start in IDLE:
  - Latch apg_n_samples=n_samples and n_eff=min(n_samples,NUM_SAMP).
  - If the write sequencer is mid-write, start is held pending until it is idle.
  - start outside IDLE is ignored.
- n_samples==0: no run; err[2] set; done pulses the next cycle; no output beats.
- ARM: apg_run=1 for exactly 1 cycle, then WAIT_DONE.
- WAIT_DONE: when apg_status[1:0]==2, go to WAIT_IDLE.
- WAIT_IDLE: when apg_status[1:0]==0 and apg_status[2]==0, go to DRAIN_PRESENT with idx=0.
- DRAIN_PRESENT:
  - Register m_tdata=apg_read_channel; m_tvalid=1; m_tlast=(idx==n_eff-1).
  - Hold until m_tready; m_tdata stable while stalled.
  - After handshake: if last, done=1 for 1 cycle, load_count←0, go IDLE. Otherwise go DRAIN_STEP.
- DRAIN_STEP:
  - apg_rd_strobe=1 for exactly 1 cycle, then 2 wait cycles with the strobe low.
  - idx++, then return to DRAIN_PRESENT.
  - Inter-beat gap ≥3 cycles.
- Timeout:
  - A counter runs in WAIT_DONE/WAIT_IDLE and resets on state entry.
  - Reaching TIMEOUT sets err[1], pulses apg_clear for 1 cycle, goes IDLE, no done.
  - Covers loop mode, which never reaches DONE.
- soft_clear, any state and highest priority:
  - apg_clear=1 next cycle for 1 cycle.
  - FSM IDLE; m_tvalid=0; write sequencer aborted (strobe not issued if not yet issued).
  - load_count=0; err cleared; pending start dropped.
- Simultaneous start and soft_clear: soft_clear wins, start dropped.
- apg_rd_strobe and apg_wr_strobe are never high on consecutive cycles, and never both high in the same cycle.
- apg_status is used as delivered (already synchronized to axi_clk).

Test Plan:
- Reset: s_tvalid=1 during reset → no strobe, all outputs 0; after release s_tready=1, first strobe 1 cycle after the first accept.
- Load 5 words 0x0001..0x0005, s_tvalid constant → 5 single-cycle strobes spaced 4 cycles, data stable each strobe+1 cycle, load_count=5.
- Load 130 words with NUM_SAMP=128 → 128 strobes, err[0]=1, load_count=128.
- start with n_samples=4; model status 0→1→2→0 with input samples 0xA,0xB,0xC,0xD → 1 run pulse, 3 rd_strobes, m_tdata A,B,C,D, tlast on D, one done pulse.
- Drain with m_tready low for 10 cycles on beat 2 → m_tdata held, no extra rd_strobe, order preserved.
- Status stuck at 1, TIMEOUT=64 → err[1]=1 after 64 cycles, 1 apg_clear pulse, IDLE. Separately, soft_clear mid-drain → m_tvalid=0 next cycle, apg_clear pulse. Separately, start with n_samples=0 → err[2]=1, done pulse, no run.
